flash_period_meter: RTL and testbench
=====================================

# flash_period_meter

Measures the period and high time of a slow square wave on a single input pin, such as a blink signal, a heartbeat from another board, or a pushbutton line. Reports each completed measurement with a one-cycle valid strobe, and flags a stuck input when no rising edge arrives within a timeout window. It is the receive-side counterpart to the board's LED blink generator, and its result bus feeds the Qsys register slave.

## Interface
- OSC_CLOCK, 27000000: in_clk frequency in Hz; only used to derive the TIMEOUT default.
- CNT_W, 28: width of the cycle counter and of the result outputs.
- TIMEOUT, OSC_CLOCK: cycles without a rising edge before `stuck` asserts. Must be at least 4 and at most 2^CNT_W−1.

- in_clk, input, 1: system clock. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- sig_in, input, 1: measured signal. Asynchronous to in_clk.
- period, output, CNT_W: in_clk cycles between the last two detected rising edges.
- high_time, output, CNT_W: in_clk cycles from the last detected rising edge to the following falling edge.
- period_valid, output, 1: one-cycle strobe when `period` and `high_time` update.
- stuck, output, 1: no rising edge seen within TIMEOUT cycles.
- level, output, 1: synchronized copy of sig_in.

## Operation
- **Synchronizer:** two flops, s1 then s2. A third flop, s3, holds the previous s2.
  - rise = s2 & ~s3
  - fall = ~s2 & s3
  - level = s2
- **States:**
  - ARM: wait for the first rising edge.
  - RUN: measuring.
- **Counter `cnt`:**
  - Loads 1 on the cycle after each rise.
  - Otherwise increments by 1 and saturates at TIMEOUT.
  - With rises D cycles apart, cnt equals D on the cycle of the second rise.
- **ARM state:**
  - On rise: go to RUN, load cnt to 1, clear hi_latch.
  - cnt is not compared against TIMEOUT.
- **RUN state:**
  - On fall: hi_latch ← cnt.
  - On rise:
    - period ← cnt.
    - high_time ← hi_latch if a fall was seen since the previous rise, otherwise cnt.
    - period_valid ← 1 for one cycle.
    - cnt ← 1, stuck ← 0.
  - When cnt reaches TIMEOUT with no rise: stuck ← 1, go to ARM. period, high_time and period_valid are not touched.
- **After a timeout:** the next rise starts a fresh measurement. The first rise after ARM never produces period_valid.
- **Simultaneous events:** rise and fall cannot occur in the same cycle, by construction of the edge detector. A rise on the same cycle that cnt reaches TIMEOUT is treated as a rise: the measurement is accepted and the timeout is ignored.
- **Arithmetic:** unsigned, CNT_W bits. Saturation guarantees no wrap-around.
- **Reset:**
  - s1, s2, s3 and level are 0.
  - period, high_time, hi_latch and period_valid are 0.
  - cnt is 0, stuck is 0, state is ARM.
  - Reset mid-measurement discards the measurement in progress. No valid strobe is issued.

## Timing
- sig_in is sampled by s1 on in_clk edge k.
- The rise or fall is decoded combinationally after edge k+2.
- Result registers and period_valid update on edge k+3. Input-to-strobe latency is 3 cycles.
- period and high_time hold their values until the next period_valid.
- stuck asserts on the edge after cnt reaches TIMEOUT.
- stuck deasserts on the same edge that period_valid would fire for the next qualifying rise. After ARM, that is the second rise.
- A pulse on sig_in shorter than one in_clk period may be missed. Debouncing is out of scope.

## Test plan
- **Nominal waveform:** TIMEOUT=100. sig_in square wave, period 20 cycles, high 8 cycles, 5 periods.
  - First rise: no strobe.
  - Then 4 period_valid strobes, each with period=20 and high_time=8, spaced 20 cycles apart.
  - stuck=0 throughout.
- **Latency:** drive sig_in high at the first rise of a running wave. period_valid is seen exactly 3 edges after the first edge that samples it high.
- **Timeout:** after a valid measurement, hold sig_in low.
  - stuck=1 exactly TIMEOUT cycles after the last cnt reload.
  - period and high_time hold 20 and 8.
  - Restarting the wave gives the first strobe at the second rise, and stuck clears with it.
- **Stuck high:** hold sig_in high for 150 cycles with TIMEOUT=100. stuck=1 and no strobe.
- **Reset mid-measurement:** assert reset for 2 cycles between two rises.
  - All outputs go to 0 asynchronously, before any in_clk edge.
  - No strobe until two further rises.
- **Asymmetric and boundary periods:** TIMEOUT=100.
  - Period 3 with high 1: period=3, high_time=1.
  - Period 99: period=99, stuck=0.
  - Second rise 100 cycles after the first: accepted, period=100, stuck=0.

Source files
------------

// File: rtl/flash_period_meter.sv
// Measures period and high time of a slow square wave on sig_in, strobing each
// completed measurement and flagging a stuck input after TIMEOUT cycles without a rise.
module flash_period_meter #(
    parameter int OSC_CLOCK = 27000000,
    parameter int CNT_W     = 28,
    parameter int TIMEOUT   = OSC_CLOCK
) (
    input  logic             in_clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             stuck,
    output logic             level
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};

    typedef enum logic [0:0] {
        ARM = 1'b0,
        RUN = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             s1_r;
    logic             s2_r;
    logic             s3_r;
    logic             rise_r;
    logic             fall_r;
    logic             fall_seen_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] hi_latch_r;
    logic             accept_s;
    logic             arm_s;
    logic             latch_hi_s;
    logic             timeout_s;

    // Synchronizer and edge detector; edge pulses are registered so results
    // land three edges after sig_in is first sampled.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            s3_r   <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            s1_r   <= sig_in;
            s2_r   <= s1_r;
            s3_r   <= s2_r;
            rise_r <= s2_r & ~s3_r;
            fall_r <= ~s2_r & s3_r;
        end
    end

    assign level = s2_r;

    // State register.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            state_r <= ARM;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and event decode; a rise always wins over a coincident timeout.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        arm_s        = 1'b0;
        latch_hi_s   = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ARM: begin
                if (rise_r) begin
                    state_next_s = RUN;
                    arm_s        = 1'b1;
                end else begin
                    state_next_s = ARM;
                end
            end
            RUN: begin
                if (rise_r) begin
                    accept_s = 1'b1;
                end else if (cnt_r == TIMEOUT_C) begin
                    timeout_s    = 1'b1;
                    state_next_s = ARM;
                end else if (fall_r) begin
                    latch_hi_s = 1'b1;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = ARM;
            end
        endcase
    end

    // Cycle counter: reloads on each rise, saturates at TIMEOUT.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            cnt_r <= ZERO_C;
        end else if (rise_r) begin
            cnt_r <= ONE_C;
        end else if (cnt_r < TIMEOUT_C) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= TIMEOUT_C;
        end
    end

    // Falling-edge capture of the high time within the current period.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            hi_latch_r  <= ZERO_C;
            fall_seen_r <= 1'b0;
        end else if (arm_s) begin
            hi_latch_r  <= ZERO_C;
            fall_seen_r <= 1'b0;
        end else if (accept_s) begin
            fall_seen_r <= 1'b0;
        end else if (latch_hi_s) begin
            hi_latch_r  <= cnt_r;
            fall_seen_r <= 1'b1;
        end
    end

    // Result registers, strobe and stuck flag.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            period       <= ZERO_C;
            high_time    <= ZERO_C;
            period_valid <= 1'b0;
            stuck        <= 1'b0;
        end else begin
            period_valid <= accept_s;
            if (accept_s) begin
                period    <= cnt_r;
                high_time <= fall_seen_r ? hi_latch_r : cnt_r;
                stuck     <= 1'b0;
            end else if (timeout_s) begin
                stuck <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flash_period_meter.sv
// Scoreboard bench for flash_period_meter: each rise that should complete a
// measurement pushes its expected period/high time; a monitor pops on every strobe.
module tb_flash_period_meter;

    localparam int CNT_W   = 28;
    localparam int TIMEOUT = 100;

    typedef struct packed {
        logic [CNT_W-1:0] p;
        logic [CNT_W-1:0] h;
    } exp_t;

    logic             in_clk = 1'b0;
    logic             reset;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             stuck;
    logic             level;

    exp_t exp_q[$];
    exp_t exp_e;
    exp_t exp_tmp;
    int   strobe_cyc_q[$];
    int   vectors         = 0;
    int   miscompares     = 0;
    int   strobes         = 0;
    int   cyc             = 0;
    int   last_strobe_cyc = 0;
    bit   stuck_seen      = 1'b0;
    bit   model_run       = 1'b0;
    int   p_prev          = 0;
    int   h_prev          = 0;

    flash_period_meter #(
        .OSC_CLOCK(27000000),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .in_clk      (in_clk),
        .reset       (reset),
        .sig_in      (sig_in),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .stuck       (stuck),
        .level       (level)
    );

    always #5 in_clk = ~in_clk;

    always @(posedge in_clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge in_clk) begin
        if (stuck === 1'b1) stuck_seen = 1'b1;
        if (period_valid === 1'b1) begin
            strobes++;
            last_strobe_cyc = cyc;
            strobe_cyc_q.push_back(cyc);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL strobe_unexpected: got period=%0d high_time=%0d, required no strobe",
                         period, high_time);
            end else begin
                exp_e = exp_q.pop_front();
                if (period !== exp_e.p || high_time !== exp_e.h) begin
                    miscompares++;
                    $display("FAIL strobe_result: got period=%0d high_time=%0d, required period=%0d high_time=%0d",
                             period, high_time, exp_e.p, exp_e.h);
                end
                vectors++;
                if (stuck !== 1'b0) begin
                    miscompares++;
                    $display("FAIL strobe_stuck: got stuck=%b, required 0", stuck);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    // One high-then-low pulse; pushes the result the rise should complete.
    task automatic pulse(input int h, input int l);
        sig_in = 1'b1;
        if (model_run && (p_prev <= TIMEOUT)) begin
            exp_tmp.p = CNT_W'(p_prev);
            exp_tmp.h = CNT_W'(h_prev);
            exp_q.push_back(exp_tmp);
        end
        model_run = 1'b1;
        tick(h);
        sig_in = 1'b0;
        tick(l);
        p_prev = h + l;
        h_prev = h;
    endtask

    task automatic apply_reset();
        @(negedge in_clk);
        reset  = 1'b1;
        sig_in = 1'b0;
        tick(2);
        reset     = 1'b0;
        model_run = 1'b0;
        tick(2);
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d pending strobes, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        tick(3);
        vectors++;
        if ({period, high_time, period_valid, stuck, level} !== {(2*CNT_W+3){1'b0}}) begin
            miscompares++;
            $display("FAIL reset_during: got period=%0d high_time=%0d valid=%b stuck=%b level=%b, required all 0",
                     period, high_time, period_valid, stuck, level);
        end
        reset = 1'b0;
        tick(3);
        vectors++;
        if ({period, high_time, period_valid, stuck, level} !== {(2*CNT_W+3){1'b0}}) begin
            miscompares++;
            $display("FAIL reset_after: got period=%0d high_time=%0d valid=%b stuck=%b level=%b, required all 0",
                     period, high_time, period_valid, stuck, level);
        end
    endtask

    task automatic test_nominal();
        int s0;
        s0 = strobes;
        stuck_seen = 1'b0;
        strobe_cyc_q.delete();
        repeat (5) pulse(8, 12);
        vectors++;
        if (strobes - s0 != 4) begin
            miscompares++;
            $display("FAIL nominal_count: got %0d strobes, required 4", strobes - s0);
        end
        for (int i = 1; i < strobe_cyc_q.size(); i++) begin
            vectors++;
            if (strobe_cyc_q[i] - strobe_cyc_q[i-1] != 20) begin
                miscompares++;
                $display("FAIL nominal_spacing: got %0d cycles, required 20",
                         strobe_cyc_q[i] - strobe_cyc_q[i-1]);
            end
        end
        vectors++;
        if (stuck_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL nominal_stuck: got stuck=1 during wave, required 0");
        end
        check_drained("nominal");
    endtask

    task automatic test_latency();
        int n;
        n = 0;
        sig_in = 1'b1;
        exp_tmp.p = CNT_W'(p_prev);
        exp_tmp.h = CNT_W'(h_prev);
        exp_q.push_back(exp_tmp);
        do begin
            tick(1);
            n++;
        end while (period_valid !== 1'b1 && n < 10);
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL latency: got strobe %0d edges after first sampling edge, required 3", n - 1);
        end
        tick((n < 8) ? (8 - n) : 0);
        sig_in = 1'b0;
        tick(12);
        p_prev = 20;
        h_prev = 8;
        check_drained("latency");
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        while (stuck !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        vectors++;
        if (cyc - last_strobe_cyc != TIMEOUT) begin
            miscompares++;
            $display("FAIL timeout_delay: got stuck %0d cycles after reload, required %0d",
                     cyc - last_strobe_cyc, TIMEOUT);
        end
        vectors++;
        if (period !== 28'd20 || high_time !== 28'd8) begin
            miscompares++;
            $display("FAIL timeout_hold: got period=%0d high_time=%0d, required 20 and 8", period, high_time);
        end
        p_prev = 999;
        tick(5);
        pulse(8, 12);
        vectors++;
        if (stuck !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_first_rise: got stuck=%b, required 1", stuck);
        end
        pulse(8, 12);
        pulse(8, 12);
        tick(4);
        vectors++;
        if (stuck !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_restart: got stuck=%b, required 0", stuck);
        end
        check_drained("timeout");
    endtask

    task automatic test_stuck_high();
        int s0;
        apply_reset();
        s0 = strobes;
        pulse(150, 10);
        vectors++;
        if (stuck !== 1'b1) begin
            miscompares++;
            $display("FAIL stuck_high_flag: got stuck=%b, required 1", stuck);
        end
        vectors++;
        if (strobes != s0) begin
            miscompares++;
            $display("FAIL stuck_high_strobe: got %0d strobes, required 0", strobes - s0);
        end
        check_drained("stuck_high");
    endtask

    task automatic test_reset_mid();
        int s0;
        pulse(8, 12);
        pulse(8, 12);
        sig_in = 1'b1;
        exp_tmp.p = CNT_W'(20);
        exp_tmp.h = CNT_W'(8);
        exp_q.push_back(exp_tmp);
        tick(6);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({period, high_time, period_valid, stuck, level} !== {(2*CNT_W+3){1'b0}}) begin
            miscompares++;
            $display("FAIL reset_mid_async: got period=%0d high_time=%0d valid=%b stuck=%b level=%b, required all 0",
                     period, high_time, period_valid, stuck, level);
        end
        @(negedge in_clk);
        sig_in = 1'b0;
        tick(1);
        reset     = 1'b0;
        model_run = 1'b0;
        tick(20);
        s0 = strobes;
        pulse(8, 12);
        vectors++;
        if (strobes != s0) begin
            miscompares++;
            $display("FAIL reset_mid_first_rise: got %0d strobes, required 0", strobes - s0);
        end
        pulse(8, 12);
        pulse(8, 12);
        vectors++;
        if (strobes - s0 != 2) begin
            miscompares++;
            $display("FAIL reset_mid_resume: got %0d strobes, required 2", strobes - s0);
        end
        check_drained("reset_mid");
    endtask

    task automatic test_boundary();
        apply_reset();
        repeat (4) pulse(1, 2);
        pulse(50, 49);
        pulse(40, 60);
        pulse(40, 61);
        pulse(8, 12);
        vectors++;
        if (stuck !== 1'b1) begin
            miscompares++;
            $display("FAIL boundary_101_stuck: got stuck=%b, required 1", stuck);
        end
        pulse(8, 12);
        tick(4);
        vectors++;
        if (stuck !== 1'b0) begin
            miscompares++;
            $display("FAIL boundary_restart_stuck: got stuck=%b, required 0", stuck);
        end
        check_drained("boundary");
    endtask

    initial begin
        reset  = 1'b1;
        sig_in = 1'b0;
        test_reset();
        test_nominal();
        test_latency();
        test_timeout();
        test_stuck_high();
        test_reset_mid();
        test_boundary();
        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
